// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline hazard/control unit.
package pipe_pkg;

    localparam logic [2:0] OP_HALT = 3'b111;
    localparam logic [2:0] OP_LDR  = 3'b011;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } haz_state_t;

endpackage

// File: rtl/fwd_mux_sel.sv
// Per-operand match and forwarding select; one instance per source register.
// Forwarding select is active only when HAZ_FORWARD_EN is defined.
module fwd_mux_sel
    import pipe_pkg::*;
#(
    parameter int REG_AW      = 3,
    parameter int ZERO_REG_RO = 1
) (
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wr,
    output logic              match_ex,
    output logic              match_mem,
    output fwd_sel_t          sel
);

    logic src_ok;
    logic match_wb;

    // r0 is hard-wired, so a write to it never produces a value worth waiting for.
    assign src_ok    = used && ((ZERO_REG_RO == 0) || (src != '0));
    assign match_ex  = src_ok && ex_wr  && (ex_rd  == src);
    assign match_mem = src_ok && mem_wr && (mem_rd == src);
    assign match_wb  = src_ok && wb_wr  && (wb_rd  == src);

`ifdef HAZ_FORWARD_EN
    // NOTE: default first, then overrides, so no path leaves sel unassigned (no latch).
    always_comb begin
        sel = FWD_RF;
        if (match_mem) begin
            sel = FWD_MEM;
        end else if (match_wb) begin
            sel = FWD_WB;
        end
    end
`else
    logic unused_wb;
    assign sel       = FWD_RF;
    assign unused_wb = match_wb;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit: forwarding, load-use bubbles, branch flush, halt FSM.
// Build option: HAZ_FORWARD_EN enables operand forwarding; otherwise EX/MEM matches stall.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = 3,
    parameter int MEM_LAT     = 1,
    parameter int DRAIN_CYC   = 3,
    parameter int ZERO_REG_RO = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [2:0]        id_opcode,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wr,
    input  logic              ex_br_taken,
    input  logic              resume,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              pc_load,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              halted
);

    localparam int DC_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

    haz_state_t      state_q, state_d;
    logic [2:0]      lu_cnt_q, lu_cnt_d;
    logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;

    logic     a_ex, a_mem, b_ex, b_mem;
    fwd_sel_t sel_a, sel_b;
    logic     lu_trig, lu_busy, raw_stall;

    fwd_mux_sel #(.REG_AW(REG_AW), .ZERO_REG_RO(ZERO_REG_RO)) u_fwd_rs (
        .src(id_rs), .used(id_rs_used),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .wb_rd(wb_rd), .wb_wr(wb_wr),
        .match_ex(a_ex), .match_mem(a_mem), .sel(sel_a)
    );

    fwd_mux_sel #(.REG_AW(REG_AW), .ZERO_REG_RO(ZERO_REG_RO)) u_fwd_rt (
        .src(id_rt), .used(id_rt_used),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .wb_rd(wb_rd), .wb_wr(wb_wr),
        .match_ex(b_ex), .match_mem(b_mem), .sel(sel_b)
    );

    assign lu_trig = ex_load && (a_ex || b_ex);
    assign lu_busy = (lu_cnt_q != '0) || lu_trig;

`ifdef HAZ_FORWARD_EN
    assign raw_stall = 1'b0;
`else
    assign raw_stall = a_ex || a_mem || b_ex || b_mem;
`endif

    always_comb begin
        state_d     = state_q;
        lu_cnt_d    = lu_cnt_q;
        drain_cnt_d = drain_cnt_q;
        fwd_a       = sel_a;
        fwd_b       = sel_b;
        stall       = 1'b0;
        pc_load     = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        halted      = 1'b0;

        if (!reset_n) begin
            // Outputs show reset values at once, whatever the inputs claim.
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
        end else if (ex_br_taken && (state_q != HALTED)) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            lu_cnt_d    = '0;
            drain_cnt_d = '0;
            state_d     = RUN;
        end else begin
            unique case (state_q)
                DRAIN: begin
                    stall       = 1'b1;
                    pc_load     = 1'b0;
                    flush_id_ex = 1'b1;
                    if (drain_cnt_q <= DC_W'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DC_W'(1);
                    end
                end
                HALTED: begin
                    halted      = 1'b1;
                    flush_id_ex = 1'b1;
                    if (resume) begin
                        // Restart fetch and squash the HALT still sitting in IF_ID.
                        flush_if_id = 1'b1;
                        state_d     = RUN;
                    end else begin
                        stall   = 1'b1;
                        pc_load = 1'b0;
                    end
                end
                default: begin
                    if (lu_busy) begin
                        stall       = 1'b1;
                        pc_load     = 1'b0;
                        flush_id_ex = 1'b1;
                        lu_cnt_d    = (lu_cnt_q != '0) ? lu_cnt_q - 3'd1 : 3'(MEM_LAT - 1);
                    end else if (id_opcode == OP_HALT) begin
                        // The detection cycle counts as the first drain cycle.
                        stall       = 1'b1;
                        pc_load     = 1'b0;
                        flush_id_ex = 1'b1;
                        drain_cnt_d = DC_W'(DRAIN_CYC - 1);
                        state_d     = (DRAIN_CYC <= 1) ? HALTED : DRAIN;
                    end else if (raw_stall) begin
                        stall       = 1'b1;
                        pc_load     = 1'b0;
                        flush_id_ex = 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            lu_cnt_q    <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_LAT = 3, DRAIN_CYC = 3).
// Expected forwarding/stall values follow whether HAZ_FORWARD_EN is defined.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

`ifdef HAZ_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] id_rs, id_rt, id_opcode, ex_rd, mem_rd, wb_rd;
    logic       id_rs_used, id_rt_used, ex_wr, ex_load, mem_wr, wb_wr;
    logic       ex_br_taken, resume;
    logic [1:0] fwd_a, fwd_b;
    logic       stall, pc_load, flush_if_id, flush_id_ex, halted;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(3), .MEM_LAT(3), .DRAIN_CYC(3), .ZERO_REG_RO(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_opcode(id_opcode),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_rd(wb_rd), .wb_wr(wb_wr),
        .ex_br_taken(ex_br_taken), .resume(resume),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .pc_load(pc_load),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; id_opcode = 3'b000;
        ex_rd = 0; ex_wr = 0; ex_load = 0; mem_rd = 0; mem_wr = 0;
        wb_rd = 0; wb_wr = 0; ex_br_taken = 0; resume = 0;
    endtask

    // Advance to just after the next rising edge, where inputs change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the stall-group outputs as {stall, pc_load, flush_if_id, flush_id_ex, halted}.
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        #1;
        check(tag, {stall, pc_load, flush_if_id, flush_id_ex, halted}, exp);
    endtask

    localparam logic [4:0] CTL_IDLE  = 5'b01000;
    localparam logic [4:0] CTL_STALL = 5'b10010;
    localparam logic [4:0] CTL_HALT  = 5'b10011;
    localparam logic [4:0] CTL_FLUSH = 5'b01110;

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        check_ctl("reset_ctl", CTL_IDLE);
        check("reset_fwd", {fwd_a, fwd_b}, 4'b0000);
        tick();
        reset_n = 1'b1;
        tick();

        // Forwarding: EX_MEM beats MEM_WB; r0 never forwards.
        id_rs = 2; id_rs_used = 1; mem_wr = 1; mem_rd = 2; wb_wr = 1; wb_rd = 2;
        check_ctl("fwd_mem_ctl", FWD_ON ? CTL_IDLE : CTL_STALL);
        check("fwd_mem", fwd_a, FWD_ON ? 2'b10 : 2'b00);
        mem_rd = 3;
        check_ctl("fwd_wb_ctl", CTL_IDLE);
        check("fwd_wb", fwd_a, FWD_ON ? 2'b01 : 2'b00);
        id_rs = 0; mem_rd = 0; wb_rd = 0;
        check_ctl("fwd_r0_ctl", CTL_IDLE);
        check("fwd_r0", fwd_a, 2'b00);
        clear_inputs();
        id_rt = 5; id_rt_used = 1; wb_wr = 1; wb_rd = 5;
        #1 check("fwd_b_wb", fwd_b, FWD_ON ? 2'b01 : 2'b00);
        id_rt_used = 0;
        #1 check("fwd_b_unused", fwd_b, 2'b00);
        tick();

        // Load-use: stall exactly MEM_LAT = 3 cycles, then forward from WB.
        clear_inputs();
        ex_load = 1; ex_wr = 1; ex_rd = 4; id_rt = 4; id_rt_used = 1;
        check_ctl("lu_c1", CTL_STALL);
        tick();
        ex_load = 0; ex_wr = 0; mem_wr = 1; mem_rd = 4;
        check_ctl("lu_c2", CTL_STALL);
        tick();
        mem_wr = 0;
        check_ctl("lu_c3", CTL_STALL);
        tick();
        wb_wr = 1; wb_rd = 4;
        check_ctl("lu_done", CTL_IDLE);
        check("lu_fwd_b", fwd_b, FWD_ON ? 2'b01 : 2'b00);
        tick();

        // Halt: three stall cycles, halted on cycle 4, resume restarts fetch.
        clear_inputs();
        id_opcode = OP_HALT;
        for (int c = 1; c <= 3; c++) begin
            check_ctl($sformatf("halt_drain_c%0d", c), CTL_STALL);
            tick();
        end
        check_ctl("halt_c4", CTL_HALT);
        tick();
        check_ctl("halt_hold", CTL_HALT);
        resume = 1;
        #1 check("resume_out", {stall, pc_load, flush_if_id}, 3'b011);
        tick();
        resume = 0; id_opcode = 3'b000;
        check_ctl("after_resume", CTL_IDLE);
        tick();

        // Taken branch on the second DRAIN cycle aborts the halt.
        id_opcode = OP_HALT;
        tick();
        tick();
        ex_br_taken = 1;
        check_ctl("br_in_drain", CTL_FLUSH);
        tick();
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            check_ctl($sformatf("br_no_halt_%0d", c), CTL_IDLE);
            tick();
        end

        // Branch overrides a load-use trigger and clears the counter.
        ex_load = 1; ex_wr = 1; ex_rd = 4; id_rs = 4; id_rs_used = 1; ex_br_taken = 1;
        check_ctl("br_over_lu", CTL_FLUSH);
        tick();
        clear_inputs();
        check_ctl("br_lu_clear", CTL_IDLE);
        tick();

        // Reset while lu_cnt = 2 returns to idle immediately.
        ex_load = 1; ex_wr = 1; ex_rd = 4; id_rt = 4; id_rt_used = 1;
        tick();
        reset_n = 0;
        check_ctl("rst_mid_lu", CTL_IDLE);
        clear_inputs();
        tick();
        reset_n = 1;
        check_ctl("rst_release", CTL_IDLE);
        tick();
        check_ctl("rst_no_stall", CTL_IDLE);
        tick();

        // HALT arriving during a load-use stall waits for the stall to end.
        ex_load = 1; ex_wr = 1; ex_rd = 4; id_rt = 4; id_rt_used = 1;
        tick();
        clear_inputs();
        id_opcode = OP_HALT;
        tick();
        tick();
        check_ctl("halt_defer_det", CTL_STALL);
        tick();
        tick();
        check_ctl("halt_defer_c3", CTL_STALL);
        tick();
        check_ctl("halt_defer_halted", CTL_HALT);
        resume = 1;
        tick();
        clear_inputs();
        check_ctl("halt_defer_run", CTL_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
